fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core. Sits directly upstream of decode and supplies `instr_code` plus its PC. It drives a synchronous-read instruction BRAM (1-cycle read latency) and holds a PC register that advances sequentially or takes a redirect from execute on taken branch/JAL/JALR. A 1-entry skid buffer absorbs the in-flight BRAM response when decode stalls, so no instruction is lost or duplicated.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC register, synchronous-read BRAM request path,
// and a one-entry skid buffer that keeps the in-flight word when decode stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               stall,
  output logic [31:0]        instr_code,
  output logic [31:0]        instr_pc,
  output logic               instr_valid
);

  logic [31:0] pc_r;
  logic [31:0] req_pc_r;
  logic        req_pending_r;
  logic [31:0] skid_code_r;
  logic [31:0] skid_pc_r;
  logic        skid_valid_r;
  logic [31:0] instr_code_r;
  logic [31:0] instr_pc_r;
  logic        instr_valid_r;

  logic        issue_s;
  logic        ld_s;
  logic [31:0] fetch_addr_s;

  // Issue decision, word-aligned fetch address and output load enable
  always_comb begin
    issue_s      = redirect | ~stall;
    ld_s         = ~stall | ~instr_valid_r;
    fetch_addr_s = (redirect ? redirect_pc : pc_r) & ~32'h0000_0003;
  end

  assign imem_en     = issue_s & rst_n;
  assign imem_addr   = fetch_addr_s[IMEM_AW+1:2];
  assign instr_code  = instr_code_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;

  // PC advance and tracking of the request whose data returns next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      req_pc_r      <= 32'h0000_0000;
      req_pending_r <= 1'b0;
    end else begin
      req_pending_r <= issue_s;
      if (issue_s) begin
        pc_r     <= fetch_addr_s + 32'd4;
        req_pc_r <= fetch_addr_s;
      end else begin
        pc_r     <= pc_r;
        req_pc_r <= req_pc_r;
      end
    end
  end

  // Response routing between the output register and the skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_r  <= 1'b0;
      skid_code_r   <= 32'h0000_0000;
      skid_pc_r     <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      instr_code_r  <= NOP;
      instr_pc_r    <= 32'h0000_0000;
    end else if (redirect) begin
      // The response arriving now belongs to the abandoned path
      skid_valid_r  <= 1'b0;
      instr_valid_r <= 1'b0;
      instr_code_r  <= NOP;
    end else if (ld_s) begin
      if (skid_valid_r) begin
        instr_valid_r <= 1'b1;
        instr_code_r  <= skid_code_r;
        instr_pc_r    <= skid_pc_r;
        skid_valid_r  <= req_pending_r;
        if (req_pending_r) begin
          skid_code_r <= imem_rdata;
          skid_pc_r   <= req_pc_r;
        end else begin
          skid_code_r <= skid_code_r;
          skid_pc_r   <= skid_pc_r;
        end
      end else if (req_pending_r) begin
        instr_valid_r <= 1'b1;
        instr_code_r  <= imem_rdata;
        instr_pc_r    <= req_pc_r;
      end else begin
        instr_valid_r <= 1'b0;
        instr_code_r  <= NOP;
      end
    end else begin
      if (req_pending_r) begin
        skid_valid_r <= 1'b1;
        skid_code_r  <= imem_rdata;
        skid_pc_r    <= req_pc_r;
      end else begin
        skid_valid_r <= skid_valid_r;
      end
    end
  end

  fetch_unit_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect),
    .ld         (ld_s),
    .resp       (req_pending_r),
    .skid_valid (skid_valid_r)
  );

endmodule

// Runtime checks for fetch_unit; the skid entry must never be overwritten.
module fetch_unit_chk (
  input logic clk,
  input logic rst_n,
  input logic redirect,
  input logic ld,
  input logic resp,
  input logic skid_valid
);

  a_skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(~redirect & ~ld & resp & skid_valid))
    else $error("fetch_unit: response arrived while skid entry occupied and output held");

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, misalignment,
// async reset and PC wrap, with a behavioural 1-cycle BRAM (word i = 0x1000_0000+i).
module tb_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_code;
  logic [31:0] instr_pc;
  logic        instr_valid;

  logic        w_stall;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_imem_en;
  logic [13:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic [31:0] w_instr_code;
  logic [31:0] w_instr_pc;
  logic        w_instr_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_code  (instr_code),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_en     (w_imem_en),
    .imem_addr   (w_imem_addr),
    .imem_rdata  (w_imem_rdata),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc),
    .stall       (w_stall),
    .instr_code  (w_instr_code),
    .instr_pc    (w_instr_pc),
    .instr_valid (w_instr_valid)
  );

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h1000_0000 + {18'd0, imem_addr};
    if (w_imem_en) w_imem_rdata <= 32'h1000_0000 + {18'd0, w_imem_addr};
  end

  task automatic test_reset();
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_en, instr_valid, instr_code, instr_pc} !== {1'b0, 1'b0, NOP_W, 32'h0}) begin
      failures++;
      $display("FAIL reset_state en=%b v=%b code=%h pc=%h exp en=0 v=0 code=%h pc=0",
               imem_en, instr_valid, instr_code, instr_pc, NOP_W);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({imem_en, imem_addr} !== {1'b1, 14'h0}) begin
      failures++;
      $display("FAIL first_issue en=%b addr=%h exp en=1 addr=0000", imem_en, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    logic [31:0] exp_code;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_latency v=%b exp 0 one cycle after release", instr_valid);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_pc   = 32'h0000_0004 * k;
      exp_code = 32'h1000_0000 + k;
      checks++;
      if ({instr_valid, instr_pc, instr_code} !== {1'b1, exp_pc, exp_code}) begin
        failures++;
        $display("FAIL seq[%0d] v=%b pc=%h code=%h exp pc=%h code=%h",
                 k, instr_valid, instr_pc, instr_code, exp_pc, exp_code);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    logic [31:0] exp_code;
    stall = 1'b1;
    #1;
    checks++;
    if (imem_en !== 1'b0) begin
      failures++;
      $display("FAIL stall_no_issue en=%b exp 0", imem_en);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({instr_valid, instr_pc, instr_code, imem_en} !== {1'b1, 32'h8, 32'h1000_0002, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold[%0d] v=%b pc=%h code=%h en=%b exp pc=00000008 code=10000002 en=0",
                 j, instr_valid, instr_pc, instr_code, imem_en);
      end
    end
    stall = 1'b0;
    #1;
    checks++;
    if ({imem_en, imem_addr} !== {1'b1, 14'h4}) begin
      failures++;
      $display("FAIL stall_resume en=%b addr=%h exp en=1 addr=0004", imem_en, imem_addr);
    end
    for (int k = 3; k < 6; k++) begin
      @(negedge clk);
      exp_pc   = 32'h0000_0004 * k;
      exp_code = 32'h1000_0000 + k;
      checks++;
      if ({instr_valid, instr_pc, instr_code} !== {1'b1, exp_pc, exp_code}) begin
        failures++;
        $display("FAIL stall_after[%0d] v=%b pc=%h code=%h exp pc=%h code=%h",
                 k, instr_valid, instr_pc, instr_code, exp_pc, exp_code);
      end
    end
  endtask

  // Redirect to tgt; expects one bubble, then tgt_word and tgt_word+4.
  task automatic test_redirect_to(input logic [31:0] tgt, input logic [31:0] exp_pc,
                                  input logic [13:0] exp_addr, input string name);
    redirect = 1'b1; redirect_pc = tgt;
    #1;
    checks++;
    if ({imem_en, imem_addr} !== {1'b1, exp_addr}) begin
      failures++;
      $display("FAIL %s_issue en=%b addr=%h exp en=1 addr=%h", name, imem_en, imem_addr, exp_addr);
    end
    @(negedge clk);
    redirect = 1'b0; redirect_pc = 32'h0;
    stall = 1'b0;
    checks++;
    if ({instr_valid, instr_code} !== {1'b0, NOP_W}) begin
      failures++;
      $display("FAIL %s_bubble v=%b code=%h exp v=0 code=%h", name, instr_valid, instr_code, NOP_W);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({instr_valid, instr_pc, instr_code} !==
          {1'b1, exp_pc + 32'd4 * k, 32'h1000_0000 + {18'd0, exp_addr} + k}) begin
        failures++;
        $display("FAIL %s_target[%0d] v=%b pc=%h code=%h exp pc=%h code=%h", name, k,
                 instr_valid, instr_pc, instr_code, exp_pc + 32'd4 * k,
                 32'h1000_0000 + {18'd0, exp_addr} + k);
      end
    end
  endtask

  task automatic test_redirect();
    test_redirect_to(32'h0000_0100, 32'h0000_0100, 14'h0040, "redirect");
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      checks++;
      if ({instr_valid, instr_pc, instr_code} !== {1'b1, 32'h104, 32'h1000_0041}) begin
        failures++;
        $display("FAIL rs_hold[%0d] v=%b pc=%h code=%h exp pc=00000104 code=10000041",
                 j, instr_valid, instr_pc, instr_code);
      end
    end
    test_redirect_to(32'h0000_0200, 32'h0000_0200, 14'h0080, "redirect_stall");
  endtask

  task automatic test_misaligned();
    test_redirect_to(32'h0000_0102, 32'h0000_0100, 14'h0040, "misaligned");
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_en, instr_valid, instr_code} !== {1'b0, 1'b0, NOP_W}) begin
      failures++;
      $display("FAIL async_reset en=%b v=%b code=%h exp en=0 v=0 code=%h",
               imem_en, instr_valid, instr_code, NOP_W);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({imem_en, imem_addr} !== {1'b1, 14'h0}) begin
      failures++;
      $display("FAIL async_restart_issue en=%b addr=%h exp en=1 addr=0000", imem_en, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_restart_latency v=%b exp 0", instr_valid);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({instr_valid, instr_pc, instr_code} !== {1'b1, 32'd4 * k, 32'h1000_0000 + k}) begin
        failures++;
        $display("FAIL async_restart[%0d] v=%b pc=%h code=%h exp pc=%h code=%h", k,
                 instr_valid, instr_pc, instr_code, 32'd4 * k, 32'h1000_0000 + k);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_code [3];
    exp_pc[0] = 32'hFFFF_FFFC; exp_code[0] = 32'h1000_3FFF;
    exp_pc[1] = 32'h0000_0000; exp_code[1] = 32'h1000_0000;
    exp_pc[2] = 32'h0000_0004; exp_code[2] = 32'h1000_0001;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({w_imem_en, w_imem_addr} !== {1'b1, 14'h3FFF}) begin
      failures++;
      $display("FAIL wrap_issue en=%b addr=%h exp en=1 addr=3fff", w_imem_en, w_imem_addr);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({w_instr_valid, w_instr_pc, w_instr_code} !== {1'b1, exp_pc[k], exp_code[k]}) begin
        failures++;
        $display("FAIL wrap[%0d] v=%b pc=%h code=%h exp pc=%h code=%h", k,
                 w_instr_valid, w_instr_pc, w_instr_code, exp_pc[k], exp_code[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_misaligned();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
